// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read/write-side helper blocks.
// Holds the default data width, the burst controller state encoding and the counter width rule.
package fifo_pkg;

  localparam int DEFAULT_BIT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Bits needed to hold any count from 0 up to max_burst inclusive.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer with push, pop and synchronous clear.
// head is the oldest entry; a simultaneous push and pop keeps the occupancy unchanged.
module skid_buffer2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign valid   = (count != 2'd0);

  // NOTE: both storage words are reset, so head reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer: drains burst_len words from a show-ahead FIFO into a
// valid/ready stream through a two-entry skid buffer, with abort-and-flush support.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter  int MAX_BURST = 255,
  localparam int CNT_W     = cnt_width(MAX_BURST)
) (
  input  logic                 read_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic                 abort,
  input  logic [BIT_WIDTH-1:0] fifo_data_out,
  input  logic                 fifo_empty,
  output logic                 fifo_dequeue,
  output logic                 fifo_flush,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          words_read
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BURST);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] len_sat;
  logic [1:0]       skid_count;

  // Widen before comparing so the saturation test stays meaningful at any MAX_BURST.
  assign len_sat = (int'(burst_len) > MAX_BURST) ? MAX_LEN : burst_len;

  assign busy       = (state == DRAIN);
  assign done       = (state == DONE);
  assign fifo_flush = (state == FLUSH);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    fifo_dequeue = 1'b0;
    unique case (state)
      IDLE: begin
        if (abort)      state_nxt = FLUSH;
        else if (start) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = FLUSH;
        end else begin
          fifo_dequeue = !fifo_empty && (remaining != '0) &&
                         ((skid_count != 2'd2) || out_ready);
          if ((remaining == '0) && (skid_count == 2'd0)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = abort ? FLUSH : IDLE;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge read_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      words_read <= 16'd0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start && !abort) remaining <= len_sat;
      else if (state == FLUSH)                remaining <= '0;
      else if (fifo_dequeue)                  remaining <= remaining - 1'b1;
      if (fifo_dequeue) words_read <= words_read + 16'd1;
    end
  end

  skid_buffer2 #(
    .WIDTH(BIT_WIDTH)
  ) u_skid (
    .clk      (read_clock),
    .rst      (reset),
    .push     (fifo_dequeue),
    .push_data(fifo_data_out),
    .pop      (out_ready),
    .clear    (state == FLUSH),
    .head     (out_data),
    .valid    (out_valid),
    .count    (skid_count)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a behavioural show-ahead FIFO feeds the DUT,
// expected output words go into a scoreboard queue checked by an independent monitor.
module tb_fifo_burst_reader;

  logic        read_clock;
  logic        reset;
  logic        start;
  logic [7:0]  burst_len;
  logic        abort;
  logic [7:0]  fifo_data_out;
  logic        fifo_empty;
  logic        fifo_dequeue;
  logic        fifo_flush;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [15:0] words_read;

  int total = 0;
  int bad   = 0;
  int deq_total = 0;
  int done_cnt  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  fifo_burst_reader #(
    .BIT_WIDTH(8),
    .MAX_BURST(255)
  ) dut (
    .read_clock   (read_clock),
    .reset        (reset),
    .start        (start),
    .burst_len    (burst_len),
    .abort        (abort),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_dequeue (fifo_dequeue),
    .fifo_flush   (fifo_flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .words_read   (words_read)
  );

  initial begin
    read_clock = 1'b0;
    forever #5 read_clock = ~read_clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void refresh();
    fifo_empty    = (fifo_q.size() == 0);
    fifo_data_out = fifo_empty ? 8'd0 : fifo_q[0];
  endfunction

  task automatic push_word(input logic [7:0] v);
    fifo_q.push_back(v);
    refresh();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    push_word(a); push_word(b); push_word(c);
  endtask

  // Drive point of each cycle: 2 time units after the rising edge.
  task automatic tick();
    @(posedge read_clock);
    #2;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 1);
  endtask

  // Behavioural FIFO: pops or flushes on the edge where the DUT asked for it.
  always @(posedge read_clock) begin
    logic d, f;
    d = fifo_dequeue;
    f = fifo_flush;
    #1;
    if (f) fifo_q.delete();
    else if (d && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  end

  // Monitor: scoreboard compare on every accepted output word.
  always @(negedge read_clock) begin
    if (!reset) begin
      if (fifo_dequeue) deq_total++;
      if (done) done_cnt++;
      if (fifo_empty) check("deq_while_empty", {31'd0, fifo_dequeue}, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0d expected no word", out_data);
        end else begin
          check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0, wr0, d0;
    reset = 1'b1; start = 1'b0; burst_len = 8'd0; abort = 1'b0; out_ready = 1'b0;
    refresh();
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_busy_done", {30'd0, busy, done}, 0);
    check("rst_deq_flush", {30'd0, fifo_dequeue, fifo_flush}, 0);
    check("rst_words_read", {16'd0, words_read}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Burst of 3 with downstream always ready; a second start mid-burst is ignored.
    preload(8'd100, 8'd255, 8'd120);
    exp_q.push_back(8'd100); exp_q.push_back(8'd255); exp_q.push_back(8'd120);
    dc0 = done_cnt; wr0 = words_read;
    out_ready = 1'b1; burst_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0; #1;
    check("t1_deq_c1", {31'd0, fifo_dequeue}, 1);
    check("t1_busy", {31'd0, busy}, 1);
    tick(); start = 1'b1; burst_len = 8'd50; #1;
    check("t1_deq_c2", {31'd0, fifo_dequeue}, 1);
    tick(); start = 1'b0; #1;
    check("t1_deq_c3", {31'd0, fifo_dequeue}, 1);
    tick();
    check("t1_deq_c4", {31'd0, fifo_dequeue}, 0);
    wait_done(10);
    check("t1_busy_at_done", {31'd0, busy}, 0);
    tick();
    check("t1_done_one_cycle", {31'd0, done}, 0);
    check("t1_done_count", done_cnt - dc0, 1);
    check("t1_words_read", words_read - wr0, 3);
    check("t1_sb_empty", exp_q.size(), 0);

    // Backpressure: two dequeues fill the skid buffer, then the reader stalls.
    preload(8'd100, 8'd255, 8'd120);
    exp_q.push_back(8'd100); exp_q.push_back(8'd255); exp_q.push_back(8'd120);
    dc0 = done_cnt; wr0 = words_read; d0 = deq_total;
    out_ready = 1'b0; burst_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("t2_stall_deq", {31'd0, fifo_dequeue}, 0);
    check("t2_deq_count", deq_total - d0, 2);
    check("t2_words_read", words_read - wr0, 2);
    check("t2_head", {24'd0, out_data}, 100);
    tick();
    out_ready = 1'b1;
    wait_done(20);
    tick();
    check("t2_done_count", done_cnt - dc0, 1);
    check("t2_words_read_end", words_read - wr0, 3);
    check("t2_sb_empty", exp_q.size(), 0);

    // Starvation: FIFO empty at start, words arrive late.
    exp_q.push_back(8'd7); exp_q.push_back(8'd9);
    dc0 = done_cnt;
    burst_len = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("t3_busy_starved", {31'd0, busy}, 1);
      check("t3_no_deq", {31'd0, fifo_dequeue}, 0);
      tick();
    end
    push_word(8'd7); #1;
    check("t3_deq_on_arrival", {31'd0, fifo_dequeue}, 1);
    tick(); tick();
    check("t3_busy_wait2", {31'd0, busy}, 1);
    tick();
    push_word(8'd9);
    wait_done(10);
    tick();
    check("t3_done_count", done_cnt - dc0, 1);
    check("t3_sb_empty", exp_q.size(), 0);

    // Abort after the first dequeue: flush, no done.
    preload(8'd1, 8'd2, 8'd3);
    dc0 = done_cnt; wr0 = words_read;
    out_ready = 1'b0; burst_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); abort = 1'b1; #1;
    check("t4_abort_blocks_deq", {31'd0, fifo_dequeue}, 0);
    tick(); abort = 1'b0;
    check("t4_flush", {31'd0, fifo_flush}, 1);
    check("t4_busy_flush", {31'd0, busy}, 0);
    tick();
    check("t4_flush_one_cycle", {31'd0, fifo_flush}, 0);
    check("t4_out_valid", {31'd0, out_valid}, 0);
    check("t4_words_read", words_read - wr0, 1);
    check("t4_fifo_flushed", fifo_q.size(), 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t4_no_done", done_cnt - dc0, 0);

    // start and abort together in IDLE: only a flush.
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    check("t5_flush", {31'd0, fifo_flush}, 1);
    check("t5_not_busy", {31'd0, busy}, 0);
    tick();
    check("t5_idle_after", {30'd0, busy, fifo_flush}, 0);

    // burst_len = 0: no dequeue, done two cycles after start.
    push_word(8'd42);
    d0 = deq_total;
    burst_len = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("t6_busy_c1", {30'd0, busy, done}, 2);
    tick();
    check("t6_done_c2", {30'd0, busy, done}, 1);
    tick();
    check("t6_done_off", {31'd0, done}, 0);
    check("t6_no_deq", deq_total - d0, 0);
    abort = 1'b1;
    tick(); abort = 1'b0;
    tick();

    // Reset mid-burst between edges, then a clean burst.
    preload(8'd5, 8'd6, 8'd8);
    out_ready = 1'b0; burst_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    check("t7_rst_valid_data", {23'd0, out_valid, out_data}, 0);
    check("t7_rst_busy_deq", {30'd0, busy, fifo_dequeue}, 0);
    check("t7_rst_words_read", {16'd0, words_read}, 0);
    fifo_q.delete(); refresh();
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    preload(8'd11, 8'd22, 8'd33);
    exp_q.push_back(8'd11); exp_q.push_back(8'd22);
    dc0 = done_cnt;
    out_ready = 1'b1; burst_len = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_done(10);
    tick();
    check("t7_done_count", done_cnt - dc0, 1);
    check("t7_words_read", {16'd0, words_read}, 2);
    check("t7_sb_empty", exp_q.size(), 0);
    check("t7_fifo_left", fifo_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
